word_serializer: RTL and testbench

Parallel-in, serial-out transmitter that takes one WIDTH-bit word from a processor register and sends it LSB-first, one bit per accepted beat, with an optional even-parity trailer. It is the sending end for register-held data. Its upstream side is a valid/ready word load. Its downstream side is a bit-serial valid/ready stream with start-of-frame and end-of-frame markers.

---
 rtl/serializer_pkg.sv | 15 +
 rtl/piso_shift_reg.sv | 29 ++
 rtl/word_serializer.sv | 107 ++++++++++
 tb/tb_word_serializer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and counter sizing.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_t;

    // Width of the beat counter that indexes data bits 0..width-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, right-shifting register with enable and async clear.
// q is the serial output (bit 0); load wins over shift.
module piso_shift_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q
);

    logic [WIDTH-1:0] bits;

    // NOTE: flops are written only with <= so every bit samples the pre-edge neighbour value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bits <= '0;
        end else if (load) begin
            bits <= d;
        end else if (shift) begin
            bits <= {1'b0, bits[WIDTH-1:1]};
        end
    end

    assign q = bits[0];

endmodule

// File: rtl/word_serializer.sv
// LSB-first word serializer with valid/ready on both sides and an optional even-parity trailer.
// All outputs are decoded from registered state; no combinational path from out_ready or in_valid.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_sof,
    output logic             ser_eof,
    output logic             busy
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             par;
    logic             shreg_bit;
    logic             load;
    logic             shift;
    logic             last_bit;

    assign load     = (state == IDLE) && in_valid;
    assign shift    = (state == SHIFT) && out_ready;
    assign last_bit = (count == CNT_W'(WIDTH - 1));

    piso_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .d     (data_in),
        .q     (shreg_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (out_ready && last_bit) state_next = PARITY_EN ? PARITY : IDLE;
            PARITY:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Count wraps to zero on the final data beat so it never exceeds WIDTH-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            par   <= 1'b0;
        end else if (load) begin
            count <= '0;
            par   <= ^data_in;
        end else if (shift) begin
            count <= last_bit ? '0 : count + CNT_W'(1);
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        ser_sof   = 1'b0;
        ser_eof   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = shreg_bit;
                ser_sof   = (count == '0);
                ser_eof   = last_bit && !PARITY_EN;
            end
            PARITY: begin
                ser_valid = 1'b1;
                ser_bit   = par;
                ser_eof   = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench: one parity-enabled and one parity-disabled serializer share the input stimulus.
module tb_word_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        in_valid;
    logic        out_ready;

    logic p_in_ready, p_bit, p_valid, p_sof, p_eof, p_busy;
    logic n_in_ready, n_bit, n_valid, n_sof, n_eof, n_busy;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    word_serializer #(.WIDTH(32), .PARITY_EN(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (p_in_ready),
        .out_ready (out_ready),
        .ser_bit   (p_bit),
        .ser_valid (p_valid),
        .ser_sof   (p_sof),
        .ser_eof   (p_eof),
        .busy      (p_busy)
    );

    word_serializer #(.WIDTH(32), .PARITY_EN(1'b0)) dut_np (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (n_in_ready),
        .out_ready (out_ready),
        .ser_bit   (n_bit),
        .ser_valid (n_valid),
        .ser_sof   (n_sof),
        .ser_eof   (n_eof),
        .busy      (n_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Output vector {in_ready, busy, ser_valid, ser_bit, ser_sof, ser_eof} of the selected DUT.
    function automatic logic [5:0] outs(input bit np);
        return np ? {n_in_ready, n_busy, n_valid, n_bit, n_sof, n_eof}
                  : {p_in_ready, p_busy, p_valid, p_bit, p_sof, p_eof};
    endfunction

    // Sends one word and checks every beat of the selected DUT.
    // stall_at/inject_at/abort_at < 0 disable backpressure, overlap load and mid-frame reset.
    task automatic send(input string tag, input logic [31:0] word, input logic exp_par,
                        input bit np, input int stall_at, input int stall_n,
                        input int inject_at, input int abort_at);
        int          beats;
        logic [31:0] w;
        logic [5:0]  exp;
        beats = np ? 32 : 33;
        w     = word;
        step();
        check($sformatf("%s idle", tag), 32'(outs(np)), 32'h20);
        data_in  = word;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        data_in  = ~word;
        for (int i = 0; i < beats; i++) begin
            exp = {1'b0, 1'b1, 1'b1, (i < 32) ? w[i] : exp_par, (i == 0), (i == beats - 1)};
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check($sformatf("%s async reset", tag), 32'(outs(np)), 32'h20);
                step();
                reset = 1'b0;
                step();
                check($sformatf("%s after reset", tag), 32'(outs(np)), 32'h20);
                step();
                check($sformatf("%s no resume", tag), 32'(outs(np)), 32'h20);
                return;
            end
            check($sformatf("%s beat%0d", tag, i), 32'(outs(np)), 32'(exp));
            if (i == inject_at) begin
                in_valid = 1'b1;
                data_in  = 32'hDEAD_BEEF;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    step();
                    check($sformatf("%s hold%0d", tag, i), 32'(outs(np)), 32'(exp));
                end
                out_ready = 1'b1;
            end
            step();
            in_valid = 1'b0;
            data_in  = ~word;
        end
        check($sformatf("%s done", tag), 32'(outs(np)), 32'h20);
    endtask

    initial begin
        reset     = 1'b1;
        data_in   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        check("reset p", 32'(outs(1'b0)), 32'h20);
        check("reset np", 32'(outs(1'b1)), 32'h20);
        step();
        reset = 1'b0;
        step();
        check("post reset p", 32'(outs(1'b0)), 32'h20);

        // Parity values below are the hand-counted XOR of each word.
        send("single",   32'h0000_0001, 1'b1, 1'b0, -1, 0, -1, -1);
        send("par0",     32'hA5A5_A5A5, 1'b0, 1'b0, -1, 0, -1, -1);
        send("nopar",    32'hFFFF_FFFF, 1'b0, 1'b1, -1, 0, -1, -1);
        send("stall",    32'h0000_0006, 1'b0, 1'b0,  1, 3, -1, -1);
        send("overlap",  32'h8000_0001, 1'b0, 1'b0, -1, 0,  5, -1);
        send("second",   32'h0000_0001, 1'b1, 1'b0, -1, 0, -1, -1);
        send("abort",    32'h1234_5678, 1'b1, 1'b0, -1, 0, -1, 10);
        send("restart",  32'h0000_0003, 1'b0, 1'b0, -1, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
